// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch front end.
package fetch_pkg;

  // Fetch controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding
    WAIT = 2'd1,  // request outstanding, response will be kept
    DROP = 2'd2   // request outstanding, response will be discarded
  } fetch_state_e;

  localparam int unsigned DEF_WIDTH    = 16;
  localparam int unsigned DEF_PC_STEP  = 4;
  localparam int unsigned DEF_QDEPTH   = 2;
  localparam logic [15:0] DEF_RESET_PC = 16'h0000;

endpackage

// File: rtl/fetch_unit_inst_queue.sv
// Small synchronous FIFO holding fetched {pc, inst} words for decode.
module inst_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = DEF_QDEPTH,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic [DW-1:0] head
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DW-1:0] mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // A pop needs a valid head; a push needs room unless a pop frees a slot.
  assign do_pop_s  = pop && (count_r != {CW{1'b0}});
  assign do_push_s = push && ((count_r != DEPTH_C) || do_pop_s);

  // Pointer and occupancy bookkeeping; flush overrides push and pop.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; cleared on reset so the head reads zero out of reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  assign count = count_r;
  assign head  = mem_r[rd_ptr_r];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues req/ack memory
// fetches, queues returned words and handles redirects from downstream.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       WIDTH    = DEF_WIDTH,
  parameter int unsigned       PC_STEP  = DEF_PC_STEP,
  parameter int unsigned       QDEPTH   = DEF_QDEPTH,
  parameter logic [WIDTH-1:0]  RESET_PC = WIDTH'(DEF_RESET_PC)
) (
  input  logic             clock,
  input  logic             reset,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic             inst_valid,
  output logic [WIDTH-1:0] inst,
  output logic [WIDTH-1:0] inst_pc,
  input  logic             inst_ready,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc
);

  localparam int unsigned   CW       = $clog2(QDEPTH + 1);
  localparam logic [CW-1:0] QDEPTH_C = CW'(QDEPTH);

  fetch_state_e       state_r;
  logic [WIDTH-1:0]   fpc_r;
  logic               req_r;
  logic [WIDTH-1:0]   addr_r;

  logic [CW-1:0]      count_s;
  logic [CW-1:0]      count_next_s;
  logic [2*WIDTH-1:0] head_s;
  logic [2*WIDTH-1:0] push_data_s;
  logic               push_s;
  logic               pop_s;
  logic               flush_s;
  logic [WIDTH-1:0]   fpc_inc_s;

  // Only a clean ack in WAIT delivers data; a redirect in the same cycle discards it.
  assign push_s       = (state_r == WAIT) && imem_ack && !redirect;
  assign pop_s        = inst_valid && inst_ready;
  assign flush_s      = redirect;
  assign push_data_s  = {fpc_r, imem_rdata};
  assign fpc_inc_s    = fpc_r + WIDTH'(PC_STEP);
  assign count_next_s = count_s + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};

  inst_queue #(
    .DW    (2 * WIDTH),
    .DEPTH (QDEPTH)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .push_data (push_data_s),
    .pop       (pop_s),
    .flush     (flush_s),
    .count     (count_s),
    .head      (head_s)
  );

  // Fetch controller: state, fetch PC and the registered memory request.
  // addr_r follows fpc except in DROP, where the stale address is held.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      fpc_r   <= RESET_PC;
      req_r   <= 1'b0;
      addr_r  <= RESET_PC;
    end else begin
      case (state_r)
        IDLE: begin
          if (redirect) begin
            fpc_r  <= redirect_pc;
            addr_r <= redirect_pc;
          end else if (count_s < QDEPTH_C) begin
            state_r <= WAIT;
            req_r   <= 1'b1;
            addr_r  <= fpc_r;
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          if (redirect && !imem_ack) begin
            fpc_r   <= redirect_pc;
            state_r <= DROP;
          end else if (redirect && imem_ack) begin
            fpc_r   <= redirect_pc;
            addr_r  <= redirect_pc;
            state_r <= IDLE;
            req_r   <= 1'b0;
          end else if (imem_ack) begin
            fpc_r  <= fpc_inc_s;
            addr_r <= fpc_inc_s;
            if (count_next_s < QDEPTH_C) begin
              state_r <= WAIT;
            end else begin
              state_r <= IDLE;
              req_r   <= 1'b0;
            end
          end else begin
            state_r <= WAIT;
          end
        end
        DROP: begin
          if (imem_ack) begin
            state_r <= IDLE;
            req_r   <= 1'b0;
            if (redirect) begin
              fpc_r  <= redirect_pc;
              addr_r <= redirect_pc;
            end else begin
              addr_r <= fpc_r;
            end
          end else if (redirect) begin
            fpc_r <= redirect_pc;
          end else begin
            state_r <= DROP;
          end
        end
        default: begin
          state_r <= IDLE;
          req_r   <= 1'b0;
          addr_r  <= fpc_r;
        end
      endcase
    end
  end

  assign imem_req   = req_r;
  assign imem_addr  = addr_r;
  assign inst_valid = (count_s != {CW{1'b0}});
  assign inst_pc    = head_s[2*WIDTH-1:WIDTH];
  assign inst       = head_s[WIDTH-1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural variable-latency memory,
// scoreboard of expected {pc, inst} deliveries, directed phase checks.
module tb_fetch_unit;

  logic        clock;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        redirect;
  logic [15:0] redirect_pc;

  // second instance: wrap-around reset PC, zero-wait memory
  logic        reset2;
  logic        req2;
  logic [15:0] addr2;
  logic        valid2;
  logic [15:0] inst2;
  logic [15:0] pc2;

  int          n_checks = 0;
  int          n_errors = 0;
  int          lat      = 0;
  int          mcnt     = 0;
  int          cyc      = 0;
  logic        prev_req  = 1'b0;
  logic        prev_ack  = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic [31:0] sb[$];
  logic [15:0] ack_log[$];
  int          ack_cyc[$];

  fetch_unit dut (
    .clock       (clock),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_ready  (inst_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  fetch_unit #(.RESET_PC(16'hFFFC)) dut2 (
    .clock       (clock),
    .reset       (reset2),
    .imem_req    (req2),
    .imem_addr   (addr2),
    .imem_ack    (req2),
    .imem_rdata  (addr2 ^ 16'hA5A5),
    .inst_valid  (valid2),
    .inst        (inst2),
    .inst_pc     (pc2),
    .inst_ready  (1'b0),
    .redirect    (1'b0),
    .redirect_pc (16'h0000)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] log_at(input int i);
    return (i < ack_log.size()) ? {16'h0, ack_log[i]} : 32'hFFFF_FFFF;
  endfunction

  function automatic int cyc_at(input int i);
    return (i < ack_cyc.size()) ? ack_cyc[i] : -100;
  endfunction

  task automatic exp_push(input logic [15:0] pc);
    sb.push_back({pc, pc ^ 16'hA5A5});
  endtask

  // Memory model and delivery monitor, evaluated mid-cycle.
  always @(negedge clock) begin
    logic [31:0] e;
    cyc = cyc + 1;
    if (reset) begin
      mcnt       = 0;
      imem_ack   = 1'b0;
      imem_rdata = 16'h0;
      prev_req   = 1'b0;
      prev_ack   = 1'b0;
    end else begin
      if (prev_req && prev_ack) mcnt = 0;
      else if (prev_req)        mcnt = mcnt + 1;
      else                      mcnt = 0;
      imem_ack   = imem_req && (mcnt >= lat);
      imem_rdata = imem_ack ? (imem_addr ^ 16'hA5A5) : 16'h0;
      if (prev_req && !prev_ack) begin
        chk("req_hold", 32'(imem_req), 32'd1);
        chk("addr_hold", 32'(imem_addr), 32'(prev_addr));
      end
      if (imem_ack) begin
        ack_log.push_back(imem_addr);
        ack_cyc.push_back(cyc);
      end
      if (inst_valid && inst_ready && !redirect) begin
        chk("deliver_expected", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("inst_pc", 32'(inst_pc), 32'(e[31:16]));
          chk("inst", 32'(inst), 32'(e[15:0]));
        end
      end
      prev_req  = imem_req;
      prev_ack  = imem_ack;
      prev_addr = imem_addr;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset(input int l, input logic rdy);
    reset      = 1'b1;
    redirect   = 1'b0;
    inst_ready = 1'b0;
    lat        = l;
    step();
    step();
    ack_log.delete();
    ack_cyc.delete();
    sb.delete();
    reset      = 1'b0;
    inst_ready = rdy;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(sb.size()), 32'd0);
    inst_ready = 1'b0;
  endtask

  initial begin
    int n;
    int n0;
    reset = 1'b1; reset2 = 1'b1; redirect = 1'b0; redirect_pc = 16'h0;
    inst_ready = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0;

    // Reset values, latency and back-to-back streaming
    do_reset(0, 1'b1);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'h0000);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", 32'(inst), 32'h0000);
    chk("rst_pc", 32'(inst_pc), 32'h0000);
    for (int i = 0; i < 6; i++) exp_push(16'(i * 4));
    step();
    chk("e1_req", 32'(imem_req), 32'd1);
    chk("e1_addr", 32'(imem_addr), 32'h0000);
    chk("e1_valid", 32'(inst_valid), 32'd0);
    step();
    chk("e2_valid", 32'(inst_valid), 32'd1);
    chk("e2_pc", 32'(inst_pc), 32'h0000);
    chk("e2_inst", 32'(inst), 32'h0000_A5A5);
    chk("e2_addr", 32'(imem_addr), 32'h0004);
    drain("drain_stream");
    chk("seq_addr0", log_at(0), 32'h0000);
    chk("seq_addr1", log_at(1), 32'h0004);
    chk("seq_addr2", log_at(2), 32'h0008);
    chk("seq_gap01", 32'(cyc_at(1) - cyc_at(0)), 32'd1);
    chk("seq_gap12", 32'(cyc_at(2) - cyc_at(1)), 32'd1);

    // Backpressure from reset: queue fills with exactly two words
    do_reset(0, 1'b0);
    repeat (6) step();
    chk("bp_acks", 32'(ack_log.size()), 32'd2);
    chk("bp_req", 32'(imem_req), 32'd0);
    chk("bp_valid", 32'(inst_valid), 32'd1);
    chk("bp_pc", 32'(inst_pc), 32'h0000);
    chk("bp_inst", 32'(inst), 32'h0000_A5A5);
    exp_push(16'h0000); exp_push(16'h0004); exp_push(16'h0008);
    inst_ready = 1'b1;
    drain("drain_bp");

    // Redirect while IDLE with a full queue
    repeat (4) step();
    chk("full_req", 32'(imem_req), 32'd0);
    chk("full_valid", 32'(inst_valid), 32'd1);
    redirect = 1'b1; redirect_pc = 16'h0020;
    step();
    redirect = 1'b0;
    chk("rdi_valid", 32'(inst_valid), 32'd0);
    chk("rdi_req", 32'(imem_req), 32'd0);
    chk("rdi_addr", 32'(imem_addr), 32'h0020);
    sb.delete();
    exp_push(16'h0020); exp_push(16'h0024);
    step();
    chk("rdi_req2", 32'(imem_req), 32'd1);
    chk("rdi_addr2", 32'(imem_addr), 32'h0020);
    inst_ready = 1'b1;
    drain("drain_rdi");

    // Latency 3, redirect one cycle after the request for 0x0008
    do_reset(3, 1'b1);
    exp_push(16'h0000); exp_push(16'h0004);
    n = 0;
    while (!(imem_req && imem_addr == 16'h0008) && n < 100) begin
      step();
      n++;
    end
    chk("lat_req8", 32'(imem_addr), 32'h0008);
    step();
    redirect = 1'b1; redirect_pc = 16'h0040; inst_ready = 1'b0;
    n0 = ack_log.size();
    chk("lat_pre_sb", 32'(sb.size()), 32'd0);
    step();
    redirect = 1'b0;
    chk("drop_req", 32'(imem_req), 32'd1);
    chk("drop_addr", 32'(imem_addr), 32'h0008);
    chk("drop_valid", 32'(inst_valid), 32'd0);
    exp_push(16'h0040); exp_push(16'h0044);
    inst_ready = 1'b1;
    drain("drain_drop");
    chk("drop_ack_addr", log_at(n0), 32'h0008);
    chk("drop_next_addr", log_at(n0 + 1), 32'h0040);

    // Redirect in the same cycle as the ack
    do_reset(0, 1'b0);
    step();
    chk("sa_req", 32'(imem_req), 32'd1);
    redirect = 1'b1; redirect_pc = 16'h0100;
    step();
    redirect = 1'b0;
    chk("sa_req_lo", 32'(imem_req), 32'd0);
    chk("sa_valid", 32'(inst_valid), 32'd0);
    chk("sa_addr", 32'(imem_addr), 32'h0100);
    step();
    chk("sa_req2", 32'(imem_req), 32'd1);
    chk("sa_addr2", 32'(imem_addr), 32'h0100);
    exp_push(16'h0100);
    inst_ready = 1'b1;
    drain("drain_sa");
    chk("sa_log0", log_at(0), 32'h0000);
    chk("sa_log1", log_at(1), 32'h0100);

    // Wrapping reset PC and reset during WAIT
    reset2 = 1'b0;
    chk("w_rst_req", 32'(req2), 32'd0);
    chk("w_rst_addr", 32'(addr2), 32'hFFFC);
    step();
    chk("w_e1_req", 32'(req2), 32'd1);
    chk("w_e1_addr", 32'(addr2), 32'hFFFC);
    step();
    chk("w_e2_addr", 32'(addr2), 32'h0000);
    chk("w_e2_valid", 32'(valid2), 32'd1);
    chk("w_e2_pc", 32'(pc2), 32'hFFFC);
    chk("w_e2_inst", 32'(inst2), 32'h0000_5A59);
    reset2 = 1'b1;
    step();
    chk("w_rst2_req", 32'(req2), 32'd0);
    chk("w_rst2_valid", 32'(valid2), 32'd0);
    chk("w_rst2_addr", 32'(addr2), 32'hFFFC);
    reset2 = 1'b0;
    step();
    chk("w_re_req", 32'(req2), 32'd1);
    chk("w_re_addr", 32'(addr2), 32'hFFFC);
    step();
    chk("w_re_pc", 32'(pc2), 32'hFFFC);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the summary");
    $fatal(1, "watchdog");
  end

endmodule
